// File: rtl/instr_stream_encoder.sv
// Packs symbolic MIPS instruction requests into 32-bit words and writes them to consecutive
// instruction-memory locations. Optional illegal-mnemonic trap: `ENC_ILLEGAL_TRAP_EN.
module instr_stream_encoder #(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic          Finish,
  input  logic          InValid,
  output logic          InReady,
  input  logic [3:0]    Mnem,
  input  logic [4:0]    Rs,
  input  logic [4:0]    Rt,
  input  logic [4:0]    Rd,
  input  logic [15:0]   Imm,
  output logic          ImemWe,
  output logic [AW-1:0] ImemAddr,
  output logic [31:0]   ImemWdata,
  output logic [AW:0]   Count,
`ifdef ENC_ILLEGAL_TRAP_EN
  output logic          Err,
`endif
  output logic          Done
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [AW:0] Cap  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] Last = Cap - 1'b1;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q, err_d;

  logic        legal, rtype;
  logic [5:0]  op, funct;
  logic [31:0] word;
  logic        accept, do_write;

  always_comb begin
    legal = 1'b1;
    rtype = 1'b1;
    op    = 6'h00;
    funct = 6'h00;
    case (Mnem)
      4'd0: funct = 6'h20;
      4'd1: funct = 6'h22;
      4'd2: funct = 6'h24;
      4'd3: funct = 6'h25;
      4'd4: funct = 6'h2a;
      4'd5: begin op = 6'h23; rtype = 1'b0; end
      4'd6: begin op = 6'h2b; rtype = 1'b0; end
      4'd7: begin op = 6'h04; rtype = 1'b0; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      word = 32'h0000_0000;
    end else if (rtype) begin
      word = {op, Rs, Rt, Rd, 5'd0, funct};
    end else begin
      word = {op, Rs, Rt, Imm};
    end
  end

  assign InReady = (state_q == StLoad) && (count_q < Cap) && !Finish;
  // Start has priority over a simultaneous request.
  assign accept  = InValid && InReady && !Start;

`ifdef ENC_ILLEGAL_TRAP_EN
  assign do_write = accept && legal;
`else
  assign do_write = accept;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    if (Start) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (do_write) count_d = count_q + 1'b1;
      if (accept && !legal) err_d = 1'b1;
    end
    case (state_q)
      StIdle: if (Start) state_d = StLoad;
      StLoad: begin
        if (Start) begin
          state_d = StLoad;
        end else if (Finish || (do_write && count_q == Last)) begin
          state_d = StDone;
        end
      end
      StDone: if (Start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= do_write;
      if (do_write) begin
        addr_q  <= count_q[AW-1:0];
        wdata_q <= word;
      end
    end
  end

  assign ImemWe    = we_q;
  assign ImemAddr  = addr_q;
  assign ImemWdata = wdata_q;
  assign Count     = count_q;
  assign Done      = (state_q == StDone);
`ifdef ENC_ILLEGAL_TRAP_EN
  assign Err       = err_q;
`endif

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Sequential instruction encoder and loader for the single-cycle MIPS core: the producing end of the Op/Funct decode path. It accepts symbolic instruction requests (mnemonic plus register/immediate fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. It writes the words to consecutive instruction-memory locations, so a program can be built in place before the core runs and then executed by the datapath and control unit.

## Interface
- `AW`, 6: instruction-memory word-address width; capacity is 2^AW words.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `Start`  in  1  one-cycle pulse; begins a load session at word 0.
- `Finish`  in  1  one-cycle pulse; ends the load session early.
- `InValid`  in  1  request valid.
- `InReady`  out  1  encoder can accept a request this cycle.
- `Mnem`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8–15 illegal.
- `Rs`, `Rt`, `Rd`  in  5 each  register fields.
- `Imm`  in  16  immediate or branch offset, copied verbatim.
- `ImemWe`  out  1  instruction-memory write strobe.
- `ImemAddr`  out  AW  word address being written.
- `ImemWdata`  out  32  encoded instruction word.
- `Count`  out  AW+1  words written in the current session.
- `Done`  out  1  session finished; held until the next `Start`.
- `Err`  out  1  sticky illegal-mnemonic flag; present only with `ENC_ILLEGAL_TRAP_EN`.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `Start`.
  - LOAD → DONE on `Finish`, or when `Count` reaches 2^AW after a write.
  - DONE → LOAD on `Start`. `Start` in LOAD also restarts the session.
- Entering LOAD clears `Count` and the write pointer to 0, and clears `Err`.
- `InReady` = (state == LOAD) && (`Count` < 2^AW) && !`Finish`.
- A request is accepted when `InValid` && `InReady`.
- R-type encoding (ADD/SUB/AND/OR/SLT):
  - op = 0, then rs, rt, rd, shamt = 0.
  - funct = 0x20 / 0x22 / 0x24 / 0x25 / 0x2A respectively.
- I-type encoding:
  - op = 0x23 (LW), 0x2B (SW), 0x04 (BEQ), then rs, rt, Imm[15:0].
  - `Rd` is ignored.
- Word layout: {op[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0]} or {op, rs, rt, imm}.
- Each accepted legal request produces exactly one write. After the write, the pointer and `Count` increment.
- The pointer does not wrap. At `Count` = 2^AW the FSM goes to DONE, and any further `InValid` is ignored (`InReady` = 0).
- `Finish` and `InValid` in the same cycle: `Finish` wins and the request is not accepted.
- `Start` and `InValid` in the same cycle: `Start` wins and the request is not accepted.
- Reset mid-session: the session is aborted. No write is issued in the cycle after reset, and words already written are left in memory.

## Timing
- Reset values: state IDLE, `InReady` 0, `ImemWe` 0, `ImemAddr` 0, `ImemWdata` 0, `Count` 0, `Done` 0, `Err` 0.
- Latency is 1 cycle: a request accepted at edge N gives registered `ImemWe` = 1 with address and data valid during cycle N+1. `Count` updates at the same edge.
- Throughput is one request per cycle. Back-to-back accepts give back-to-back writes at consecutive addresses.
- `ImemWe` is a one-cycle strobe per accepted request and is never asserted otherwise.
- `Done` rises in the cycle after the DONE transition edge.
- A write still in flight when `Finish` arrives completes normally.

## Configuration
- `ENC_ILLEGAL_TRAP_EN` defined:
  - An accepted request with `Mnem` 8–15 sets `Err` (sticky until `Start` or reset).
  - No write is issued and `Count` does not advance.
- `ENC_ILLEGAL_TRAP_EN` undefined:
  - The `Err` port is absent.
  - An illegal mnemonic is encoded as NOP (0x00000000), written, and counted like any other word.

## Test plan
- Reset, `Start`, then ADD Rs=1 Rt=2 Rd=3 → one write, `ImemAddr`=0, `ImemWdata`=0x00221820, `Count`=1.
- LW Rs=0 Rt=8 Imm=4, then SW Rt=9 Imm=8, then BEQ Rs=1 Rt=2 Imm=0xFFFF, all back-to-back → writes at 0/1/2 of 0x8C080004, 0xAC090008, 0x1022FFFF on consecutive cycles.
- SUB/AND/OR/SLT with Rs=4 Rt=5 Rd=6 → 0x00853022, 0x00853024, 0x00853025, 0x0085302A.
- AW=2, keep `InValid` high for 6 requests → exactly 4 writes (addresses 0–3), `InReady` low afterwards, `Done`=1, `Count`=4.
- `Finish` together with `InValid` after 2 words → no third write, `Done`=1, `Count`=2. A following `Start` clears `Count` and `Done`, and the next write goes to address 0.
- `Mnem`=9 → with the macro: `Err`=1, no write, `Count` unchanged. Without it: write of 0x00000000 and `Count` increments.
